fetch_unit: RTL and testbench

Instruction fetch stage feeding Decode. Holds the PC and issues one read per cycle to a synchronous instruction memory with one-cycle latency. Presents the fetched instruction, its next-PC and a valid bit to Decode. Honours Decode's dependency, branch and GPU stalls using a one-entry skid buffer, and resumes from the writeback PC redirect after a control instruction.

---
 rtl/fetch_unit.sv | 148 ++++++++++++++
 tb/tb_fetch_unit.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, one-cycle-latency instruction memory requests,
// a one-entry skid buffer for Decode stalls and branch/redirect handling.
`timescale 1ns/1ps
module fetch_unit #(
  parameter int PC_WIDTH = 16,
  parameter int IR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                I_CLOCK,
  input  logic                I_RESET_N,
  input  logic                I_LOCK,
  input  logic                I_DepStallSignal,
  input  logic                I_BranchStallSignal,
  input  logic                I_GPUStallSignal,
  input  logic [PC_WIDTH-1:0] I_WriteBackPC,
  input  logic                I_WriteBackPCEn,
  input  logic [IR_WIDTH-1:0] I_IMemData,
  output logic [PC_WIDTH-1:0] O_IMemAddr,
  output logic                O_IMemRdEn,
  output logic                O_LOCK,
  output logic [PC_WIDTH-1:0] O_PC,
  output logic [IR_WIDTH-1:0] O_IR,
  output logic                O_FE_Valid
);

  typedef enum logic {RUN, BR_WAIT} state_e;

  localparam logic [PC_WIDTH-1:0] PC_STEP = PC_WIDTH'(4);

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d;
  logic                infl_vld_q, infl_vld_d;
  logic [PC_WIDTH-1:0] infl_pc_q, infl_pc_d;
  logic                skid_vld_q, skid_vld_d;
  logic [IR_WIDTH-1:0] skid_ir_q, skid_ir_d;
  logic [PC_WIDTH-1:0] skid_pc_q, skid_pc_d;
  logic                out_vld_q, out_vld_d;
  logic [IR_WIDTH-1:0] out_ir_q, out_ir_d;
  logic [PC_WIDTH-1:0] out_pc_q, out_pc_d;
  logic                lock_q;
  logic                stall;
  logic                br_take;
  logic                rd_en;

  assign stall   = I_DepStallSignal | I_GPUStallSignal;
  // A presented branch is only retired once no stall is holding it in place.
  assign br_take = (state_q == RUN) & I_BranchStallSignal & out_vld_q & ~stall & ~I_WriteBackPCEn;

  always_ff @(posedge I_CLOCK or negedge I_RESET_N) begin
    if (!I_RESET_N) state_q <= RUN;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (I_LOCK) begin
      if (I_WriteBackPCEn) state_d = RUN;
      else if (br_take)    state_d = BR_WAIT;
    end
  end

  always_comb begin
    rd_en = I_RESET_N & I_LOCK & (state_q == RUN) & ~stall & ~I_WriteBackPCEn
          & ~(I_BranchStallSignal & out_vld_q);
  end

  always_comb begin
    pc_d       = pc_q;
    infl_vld_d = infl_vld_q;
    infl_pc_d  = infl_pc_q;
    skid_vld_d = skid_vld_q;
    skid_ir_d  = skid_ir_q;
    skid_pc_d  = skid_pc_q;
    out_vld_d  = out_vld_q;
    out_ir_d   = out_ir_q;
    out_pc_d   = out_pc_q;
    if (I_LOCK) begin
      if (I_WriteBackPCEn) begin
        pc_d       = I_WriteBackPC;
        infl_vld_d = 1'b0;
        skid_vld_d = 1'b0;
        out_vld_d  = 1'b0;
      end else if (stall) begin
        // No request issues while stalled, so the skid never overflows.
        if (infl_vld_q) begin
          skid_vld_d = 1'b1;
          skid_ir_d  = I_IMemData;
          skid_pc_d  = infl_pc_q + PC_STEP;
        end
        infl_vld_d = 1'b0;
      end else if (br_take) begin
        out_vld_d  = 1'b0;
        infl_vld_d = 1'b0;
        skid_vld_d = 1'b0;
      end else begin
        if (skid_vld_q) begin
          out_vld_d  = 1'b1;
          out_ir_d   = skid_ir_q;
          out_pc_d   = skid_pc_q;
          skid_vld_d = 1'b0;
        end else if (infl_vld_q) begin
          out_vld_d = 1'b1;
          out_ir_d  = I_IMemData;
          out_pc_d  = infl_pc_q + PC_STEP;
        end else begin
          out_vld_d = 1'b0;
        end
        infl_vld_d = rd_en;
        infl_pc_d  = pc_q;
        if (rd_en) pc_d = pc_q + PC_STEP;
      end
    end
  end

  always_ff @(posedge I_CLOCK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      pc_q       <= RESET_PC;
      infl_vld_q <= 1'b0;
      infl_pc_q  <= '0;
      skid_vld_q <= 1'b0;
      skid_ir_q  <= '0;
      skid_pc_q  <= '0;
      out_vld_q  <= 1'b0;
      out_ir_q   <= '0;
      out_pc_q   <= '0;
      lock_q     <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      infl_vld_q <= infl_vld_d;
      infl_pc_q  <= infl_pc_d;
      skid_vld_q <= skid_vld_d;
      skid_ir_q  <= skid_ir_d;
      skid_pc_q  <= skid_pc_d;
      out_vld_q  <= out_vld_d;
      out_ir_q   <= out_ir_d;
      out_pc_q   <= out_pc_d;
      lock_q     <= I_LOCK;
    end
  end

  assign O_IMemAddr = pc_q;
  assign O_IMemRdEn = rd_en;
  assign O_LOCK     = lock_q;
  assign O_PC       = out_pc_q;
  assign O_IR       = out_ir_q;
  assign O_FE_Valid = out_vld_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed per-cycle vector table, hand-written reset and
// PC-wrap sequences, then random stalls/branches checked against a stream model.
`timescale 1ns/1ps
module tb_fetch_unit;
  localparam int PW = 16;
  localparam int IW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          lock = 1'b0, dep = 1'b0, gpu = 1'b0, br = 1'b0, wben = 1'b0;
  logic [PW-1:0] wbpc = '0;
  logic [IW-1:0] imem_data = '0;
  logic [PW-1:0] imem_addr, o_pc;
  logic [IW-1:0] o_ir;
  logic          rd_en, o_lock, o_vld;

  fetch_unit #(.PC_WIDTH(PW), .IR_WIDTH(IW), .RESET_PC('0)) dut (
    .I_CLOCK(clk), .I_RESET_N(rst_n), .I_LOCK(lock),
    .I_DepStallSignal(dep), .I_BranchStallSignal(br), .I_GPUStallSignal(gpu),
    .I_WriteBackPC(wbpc), .I_WriteBackPCEn(wben), .I_IMemData(imem_data),
    .O_IMemAddr(imem_addr), .O_IMemRdEn(rd_en), .O_LOCK(o_lock),
    .O_PC(o_pc), .O_IR(o_ir), .O_FE_Valid(o_vld)
  );

  always #5 clk = ~clk;

  // Memory word n holds the value n.
  function automatic logic [IW-1:0] mem_word(input logic [PW-1:0] a);
    return IW'(a >> 2);
  endfunction

  always @(posedge clk) if (rd_en) imem_data <= mem_word(imem_addr);

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic          l, d, g, b, w;
    logic [PW-1:0] wp;
    logic          rd;
    logic [PW-1:0] addr;
    logic          v;
    logic [IW-1:0] ir;
    logic [PW-1:0] pc;
    logic          lk;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic l, input logic d, input logic g, input logic b, input logic w,
                     input logic [PW-1:0] wp, input logic rd, input logic [PW-1:0] addr,
                     input logic v, input logic [IW-1:0] ir, input logic [PW-1:0] pc,
                     input logic lk);
    vec_t e;
    e.l = l; e.d = d; e.g = g; e.b = b; e.w = w; e.wp = wp;
    e.rd = rd; e.addr = addr; e.v = v; e.ir = ir; e.pc = pc; e.lk = lk;
    tbl.push_back(e);
  endtask

  logic [PW-1:0] exp_pc, nxt_pc, held_pc;
  logic [IW-1:0] held_ir;
  logic          hold_exp, waiting, br_pend;
  int            wait_cnt, consumed;

  initial begin
    //  l d g b w wbpc      rd addr     v ir     pc       lk
    add(1,0,0,0,0,16'h0000, 1,16'h0000, 0,32'h00,16'h0000, 0); // 0
    add(1,0,0,0,0,16'h0000, 1,16'h0004, 0,32'h00,16'h0000, 1);
    add(1,0,0,0,0,16'h0000, 1,16'h0008, 1,32'h00,16'h0004, 1);
    add(1,0,0,0,0,16'h0000, 1,16'h000C, 1,32'h01,16'h0008, 1);
    add(1,0,0,0,0,16'h0000, 1,16'h0010, 1,32'h02,16'h000C, 1);
    add(1,0,0,0,0,16'h0000, 1,16'h0014, 1,32'h03,16'h0010, 1); // 5
    add(1,0,0,0,0,16'h0000, 1,16'h0018, 1,32'h04,16'h0014, 1);
    add(1,1,0,0,0,16'h0000, 0,16'h001C, 1,32'h05,16'h0018, 1);
    add(1,1,0,0,0,16'h0000, 0,16'h001C, 1,32'h05,16'h0018, 1);
    add(1,0,1,0,0,16'h0000, 0,16'h001C, 1,32'h05,16'h0018, 1);
    add(1,0,0,0,0,16'h0000, 1,16'h001C, 1,32'h05,16'h0018, 1); // 10
    add(1,0,0,0,0,16'h0000, 1,16'h0020, 1,32'h06,16'h001C, 1);
    add(1,0,0,0,1,16'h0010, 0,16'h0024, 1,32'h07,16'h0020, 1);
    add(1,0,0,0,0,16'h0000, 1,16'h0010, 0,32'h00,16'h0000, 1);
    add(1,0,0,0,0,16'h0000, 1,16'h0014, 0,32'h00,16'h0000, 1);
    add(1,1,0,1,0,16'h0000, 0,16'h0018, 1,32'h04,16'h0014, 1); // 15
    add(1,1,0,1,0,16'h0000, 0,16'h0018, 1,32'h04,16'h0014, 1);
    add(1,0,0,1,0,16'h0000, 0,16'h0018, 1,32'h04,16'h0014, 1);
    add(1,0,0,0,0,16'h0000, 0,16'h0018, 0,32'h00,16'h0000, 1);
    add(1,0,0,0,0,16'h0000, 0,16'h0018, 0,32'h00,16'h0000, 1);
    add(1,0,0,0,1,16'h0040, 0,16'h0018, 0,32'h00,16'h0000, 1); // 20
    add(1,0,0,0,0,16'h0000, 1,16'h0040, 0,32'h00,16'h0000, 1);
    add(1,0,0,0,0,16'h0000, 1,16'h0044, 0,32'h00,16'h0000, 1);
    add(1,0,0,0,0,16'h0000, 1,16'h0048, 1,32'h10,16'h0044, 1);
    add(0,0,0,0,0,16'h0000, 0,16'h004C, 1,32'h11,16'h0048, 1);
    add(0,0,0,0,0,16'h0000, 0,16'h004C, 1,32'h11,16'h0048, 0); // 25
    add(0,0,0,0,0,16'h0000, 0,16'h004C, 1,32'h11,16'h0048, 0);
    add(0,0,0,0,0,16'h0000, 0,16'h004C, 1,32'h11,16'h0048, 0);
    add(1,0,0,0,0,16'h0000, 1,16'h004C, 1,32'h11,16'h0048, 0);
    add(1,0,0,0,0,16'h0000, 1,16'h0050, 1,32'h12,16'h004C, 1);
    add(1,0,0,0,0,16'h0000, 1,16'h0054, 1,32'h13,16'h0050, 1); // 30
    add(1,1,0,0,0,16'h0000, 0,16'h0058, 1,32'h14,16'h0054, 1);
    add(1,1,0,0,1,16'h0080, 0,16'h0058, 1,32'h14,16'h0054, 1);
    add(1,0,0,0,0,16'h0000, 1,16'h0080, 0,32'h00,16'h0000, 1);
    add(1,0,0,0,0,16'h0000, 1,16'h0084, 0,32'h00,16'h0000, 1);
    add(1,0,0,0,0,16'h0000, 1,16'h0088, 1,32'h20,16'h0084, 1); // 35

    // Reset state
    @(negedge clk);
    chk("reset vld",  32'(o_vld), 32'h0);
    chk("reset ir",   o_ir, 32'h0);
    chk("reset pc",   32'(o_pc), 32'h0);
    chk("reset lock", 32'(o_lock), 32'h0);
    chk("reset rden", 32'(rd_en), 32'h0);
    chk("reset addr", 32'(imem_addr), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      lock = tbl[i].l; dep = tbl[i].d; gpu = tbl[i].g; br = tbl[i].b;
      wben = tbl[i].w; wbpc = tbl[i].wp;
      #1;
      chk($sformatf("row%0d rden", i), 32'(rd_en), 32'(tbl[i].rd));
      chk($sformatf("row%0d addr", i), 32'(imem_addr), 32'(tbl[i].addr));
      chk($sformatf("row%0d vld", i), 32'(o_vld), 32'(tbl[i].v));
      chk($sformatf("row%0d lock", i), 32'(o_lock), 32'(tbl[i].lk));
      if (tbl[i].v) begin
        chk($sformatf("row%0d ir", i), o_ir, tbl[i].ir);
        chk($sformatf("row%0d pc", i), 32'(o_pc), 32'(tbl[i].pc));
      end
    end

    // Asynchronous reset between clock edges while a valid instruction is presented
    @(negedge clk);
    lock = 1'b1; dep = 1'b0; gpu = 1'b0; br = 1'b0; wben = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("async vld",  32'(o_vld), 32'h0);
    chk("async ir",   o_ir, 32'h0);
    chk("async pc",   32'(o_pc), 32'h0);
    chk("async lock", 32'(o_lock), 32'h0);
    chk("async rden", 32'(rd_en), 32'h0);
    chk("async addr", 32'(imem_addr), 32'h0);

    // PC wrap from 0xFFFC
    @(negedge clk);
    rst_n = 1'b1; wben = 1'b1; wbpc = 16'hFFFC;
    @(negedge clk);
    wben = 1'b0;
    #1;
    chk("wrap addr0", 32'(imem_addr), 32'hFFFC);
    chk("wrap rden",  32'(rd_en), 32'h1);
    @(negedge clk);
    #1;
    chk("wrap addr1", 32'(imem_addr), 32'h0000);
    @(negedge clk);
    #1;
    chk("wrap vld", 32'(o_vld), 32'h1);
    chk("wrap ir",  o_ir, 32'h3FFF);
    chk("wrap pc",  32'(o_pc), 32'h0000);

    // Randomized run against a stream-order model
    @(negedge clk);
    rst_n = 1'b0; lock = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    exp_pc = '0; hold_exp = 1'b0; waiting = 1'b0; br_pend = 1'b0;
    wait_cnt = 0; consumed = 0; held_ir = '0; held_pc = '0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(negedge clk);
      if (hold_exp) begin
        chk("hold vld", 32'(o_vld), 32'h1);
        chk("hold ir",  o_ir, held_ir);
        chk("hold pc",  32'(o_pc), 32'(held_pc));
      end
      if (waiting) chk("brwait vld", 32'(o_vld), 32'h0);
      lock = ($urandom_range(0, 9) != 0);
      dep  = ($urandom_range(0, 4) == 0);
      gpu  = ($urandom_range(0, 9) == 0);
      wben = 1'b0;
      if (waiting) begin
        br = 1'b0;
        if (wait_cnt > 0) wait_cnt--;
        else begin
          wben = 1'b1;
          wbpc = 16'($urandom_range(0, 16383) * 4);
        end
      end else if (br_pend) begin
        br = 1'b1;
      end else if (o_vld && $urandom_range(0, 7) == 0) begin
        br_pend = 1'b1;
        br = 1'b1;
      end else begin
        br = 1'b0;
        if ($urandom_range(0, 49) == 0) begin
          wben = 1'b1;
          wbpc = 16'($urandom_range(0, 16383) * 4);
        end
      end
      #1;
      if (waiting) chk("brwait rden", 32'(rd_en), 32'h0);
      hold_exp = o_vld && (!lock || (!wben && (dep || gpu)));
      held_ir = o_ir;
      held_pc = o_pc;
      if (lock) begin
        if (wben) begin
          exp_pc = wbpc; waiting = 1'b0; br_pend = 1'b0;
        end else if (!(dep || gpu) && o_vld) begin
          nxt_pc = exp_pc + 16'd4;
          chk("stream ir", o_ir, mem_word(exp_pc));
          chk("stream pc", 32'(o_pc), 32'(nxt_pc));
          exp_pc = nxt_pc;
          consumed++;
          if (br) begin
            waiting = 1'b1; br_pend = 1'b0;
            wait_cnt = int'($urandom_range(0, 3));
          end
        end
      end
    end
    chk("progress", 32'(consumed >= 400), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
